mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Multi-cycle multiply/divide controller for the E stage of the five-stage pipeline, sitting beside the ALU. It accepts a one-cycle start with an operation code and two 32-bit operands, and models a fixed execution latency with a busy counter. Results commit into HI/LO, and the block raises a stall request so the hazard unit holds any D-stage instruction that needs the unit.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (1..15)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  E-stage MDU instruction valid this cycle
- mdu_op  in  4  operation: NONE 0, MULT 1, MULTU 2, DIV 3, DIVU 4, MTHI 5, MTLO 6, MFHI 7, MFLO 8
- A  in  32  rs operand
- B  in  32  rt operand
- d_uses_mdu  in  1  D-stage instruction is any MDU op (mult/div/mt/mf)
- busy  out  1  long operation in progress
- md_stall  out  1  stall request to hazard unit
- HI  out  32  architectural HI
- LO  out  32  architectural LO
- mdu_out  out  32  MFHI/MFLO read data for E stage

## Operation
- States: IDLE, RUN. Counter cnt[3:0].
- IDLE & start & mdu_op in {MULT,MULTU,DIV,DIVU}:
  - compute the 64-bit result from A/B this cycle and latch it into pend_hi/pend_lo;
  - load cnt with MULT_CYCLES or DIV_CYCLES; go to RUN.
- RUN: cnt decrements each cycle. When cnt==1, HI<=pend_hi, LO<=pend_lo, cnt<=0, state returns to IDLE.
- MULT: {HI,LO} = $signed(A)*$signed(B), full 64 bits. MULTU: unsigned 64-bit product.
- DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend. DIVU: unsigned quotient and remainder.
- B==0 for DIV/DIVU: full busy period still runs; HI and LO keep their old values.
- DIV with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO with start in IDLE: HI or LO <= A at the next edge; no busy.
- MFHI/MFLO: mdu_out = HI or LO combinationally; 0 for all other ops. Reads return committed values only.
- start in RUN: ignored entirely, whatever the op. The hazard unit prevents this; the bench checks it anyway.
- md_stall = d_uses_mdu & (busy | (start & mdu_op in {MULT,MULTU,DIV,DIVU})).

## Timing
- Reset values: busy 0, md_stall 0 (when d_uses_mdu=0), HI 0, LO 0, mdu_out 0, state IDLE, cnt 0, pend 0.
- Reset asserted mid-RUN: the operation is abandoned and HI/LO clear at that edge.
- Reset has priority over start and over commit.
- Long op sequence:
  - start accepted at edge of cycle t;
  - busy is high in cycles t+1 .. t+N, with N = MULT_CYCLES or DIV_CYCLES;
  - HI/LO change at the edge ending cycle t+N;
  - in cycle t+N+1, busy is 0 and the new HI/LO are visible.
- A new long op may start in cycle t+N+1; back-to-back ops give no idle gap.
- busy is registered. md_stall is combinational from registered busy plus same-cycle start.
- MTHI/MTLO: new value is visible in the next cycle.

## Structure
- Add MDU op codes to the shared defines.v as `MDU_NONE .. `MDU_MFLO, alongside the existing ALU op codes.
- Add the state encodings `MDU_IDLE/`MDU_RUN to defines.v.
- One combinational sub-module, mdu_calc (mdu_op, A, B -> res_hi, res_lo, div_zero), holds all arithmetic.
- mdu_ctrl holds the FSM, counter, pend and HI/LO registers, and the stall logic.

## Test plan
- MULT A=0xFFFFFFFD (-3), B=5: busy exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULTU with the same operands: HI=0x00000004, LO=0xFFFFFFF1.
- DIV A=0xFFFFFFF9 (-7), B=2: busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=0xFFFFFFFF, B=16: LO=0x0FFFFFFF, HI=0x0000000F.
- DIV by zero with prior HI=0x11, LO=0x22: busy 10 cycles; HI/LO stay 0x11/0x22.
- During MULT RUN:
  - d_uses_mdu=1 gives md_stall=1 every busy cycle;
  - start with MTHI A=0xAB is ignored;
  - after commit, MFHI gives mdu_out equal to the product HI.
- MTLO A=0x1234 in IDLE gives LO=0x1234 next cycle with busy never high. Then MULT start in cycle t with d_uses_mdu=1 gives md_stall=1 in cycle t.
- Reset in the 3rd busy cycle of DIV: next cycle busy=0, HI=LO=0. No late commit occurs, and a fresh MULT starts cleanly.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: operation codes, FSM states and
// the pending-result bundle passed from arithmetic to commit.
package mdu_ctrl_pkg;

    localparam int unsigned MDU_CNT_W = 4;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        wr;
    } mdu_pend_t;

    function automatic logic mdu_is_mult(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic mdu_is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic mdu_is_long(input logic [3:0] op);
        return mdu_is_mult(op) || mdu_is_div(op);
    endfunction

endpackage

// File: rtl/mdu_ctrl_calc.sv
// Combinational MDU arithmetic: 64-bit products and
// quotient/remainder pairs, plus divide-by-zero detection.
module mdu_calc
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic        w_is_mult;
    logic        w_is_div;
    logic        w_is_signed;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_divisor;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_is_mult   = mdu_is_mult(mdu_op);
    assign w_is_div    = mdu_is_div(mdu_op);
    assign w_is_signed = (mdu_op == MDU_MULT) || (mdu_op == MDU_DIV);

    // Sign- or zero-extension makes one 64-bit multiply serve both forms.
    assign w_ext_a = {{32{w_is_signed & A[31]}}, A};
    assign w_ext_b = {{32{w_is_signed & B[31]}}, B};
    assign w_prod  = w_ext_a * w_ext_b;

    assign w_neg_a = w_is_signed & A[31];
    assign w_neg_b = w_is_signed & B[31];
    assign w_mag_a = w_neg_a ? (32'd0 - A) : A;
    assign w_mag_b = w_neg_b ? (32'd0 - B) : B;

    assign div_zero  = w_is_div && (B == 32'd0);
    assign w_divisor = div_zero ? 32'd1 : w_mag_b;

    // Magnitude division keeps 0x80000000 / -1 well defined.
    assign w_q   = w_mag_a / w_divisor;
    assign w_r   = w_mag_a % w_divisor;
    assign w_quo = (w_neg_a ^ w_neg_b) ? (32'd0 - w_q) : w_q;
    assign w_rem = w_neg_a ? (32'd0 - w_r) : w_r;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        unique case (1'b1)
            w_is_mult: begin
                res_hi = w_prod[63:32];
                res_lo = w_prod[31:0];
            end
            w_is_div: begin
                res_hi = w_rem;
                res_lo = w_quo;
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller: fixed-latency busy FSM,
// HI/LO architectural registers and hazard stall request.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        d_uses_mdu,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] mdu_out
);

    localparam logic [MDU_CNT_W-1:0] LP_MULT_N = MDU_CNT_W'(MULT_CYCLES);
    localparam logic [MDU_CNT_W-1:0] LP_DIV_N  = MDU_CNT_W'(DIV_CYCLES);

    mdu_state_e           r_state;
    logic [MDU_CNT_W-1:0] r_cnt;
    logic                 r_busy;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;
    mdu_pend_t            r_pend;

    logic                 w_long;
    logic [31:0]          w_res_hi;
    logic [31:0]          w_res_lo;
    logic                 w_div_zero;
    logic [MDU_CNT_W-1:0] w_load_cnt;

    mdu_calc u_calc (
        .mdu_op   (mdu_op),
        .A        (A),
        .B        (B),
        .res_hi   (w_res_hi),
        .res_lo   (w_res_lo),
        .div_zero (w_div_zero)
    );

    assign w_long     = mdu_is_long(mdu_op);
    assign w_load_cnt = mdu_is_mult(mdu_op) ? LP_MULT_N : LP_DIV_N;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MDU_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_pend  <= '0;
        end else begin
            unique case (r_state)
                MDU_IDLE: begin
                    if (start && w_long) begin
                        r_pend.hi <= w_res_hi;
                        r_pend.lo <= w_res_lo;
                        r_pend.wr <= ~w_div_zero;
                        r_cnt     <= w_load_cnt;
                        r_busy    <= 1'b1;
                        r_state   <= MDU_RUN;
                    end else if (start && mdu_op == MDU_MTHI) begin
                        r_hi <= A;
                    end else if (start && mdu_op == MDU_MTLO) begin
                        r_lo <= A;
                    end
                end
                MDU_RUN: begin
                    // Any start seen here is dropped; the hazard unit stalls it.
                    if (r_cnt == MDU_CNT_W'(1)) begin
                        if (r_pend.wr) begin
                            r_hi <= r_pend.hi;
                            r_lo <= r_pend.lo;
                        end
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= MDU_IDLE;
                    end else begin
                        r_cnt <= r_cnt - MDU_CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign HI       = r_hi;
    assign LO       = r_lo;
    assign md_stall = d_uses_mdu & (r_busy | (start & w_long));

    always_comb begin
        mdu_out = 32'd0;
        unique case (1'b1)
            (mdu_op == MDU_MFHI): mdu_out = r_hi;
            (mdu_op == MDU_MFLO): mdu_out = r_lo;
            default:              mdu_out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized and directed bench for mdu_ctrl against a
// cycle-level arithmetic reference model.
`timescale 1ns/1ps
module tb_mdu_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        d_uses_mdu;
    logic        busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] mdu_out;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mdu_op     (mdu_op),
        .A          (A),
        .B          (B),
        .d_uses_mdu (d_uses_mdu),
        .busy       (busy),
        .md_stall   (md_stall),
        .HI         (HI),
        .LO         (LO),
        .mdu_out    (mdu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_pwr;
    int          m_rem;

    logic        obs_busy, obs_stall;
    logic [31:0] obs_out;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_long(input logic [3:0] op);
        return op >= OP_MULT && op <= OP_DIVU;
    endfunction

    task automatic calc(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] hi,
                        output logic [31:0] lo, output logic wr);
        longint      sa, sb, p, q, r;
        logic [63:0] ua, ub, pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        hi = 32'd0;
        lo = 32'd0;
        wr = 1'b1;
        if (op == OP_MULT) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (op == OP_MULTU) begin
            pu = ua * ub;
            hi = pu[63:32];
            lo = pu[31:0];
        end else if (b == 32'd0) begin
            wr = 1'b0;
        end else if (op == OP_DIV) begin
            q  = sa / sb;
            r  = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end else begin
            hi = a % b;
            lo = a / b;
        end
    endtask

    task automatic step(input logic rst, input logic st,
                        input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic d);
        logic [31:0] e_out;
        logic        e_busy;
        @(negedge clk);
        reset = rst; start = st; mdu_op = op; A = a; B = b; d_uses_mdu = d;
        #1;
        e_busy = (m_rem != 0);
        e_out  = (op == OP_MFHI) ? m_hi : (op == OP_MFLO) ? m_lo : 32'd0;
        obs_busy = busy; obs_stall = md_stall; obs_out = mdu_out;
        chk("busy", {31'd0, busy}, {31'd0, e_busy});
        chk("stall", {31'd0, md_stall},
            {31'd0, d & (e_busy | (st & is_long(op)))});
        chk("hi", HI, m_hi);
        chk("lo", LO, m_lo);
        chk("mdu_out", mdu_out, e_out);
        @(posedge clk);
        if (rst) begin
            m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwr = 0; m_rem = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && m_pwr) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (st && is_long(op)) begin
            calc(op, a, b, m_phi, m_plo, m_pwr);
            m_rem = (op <= OP_MULTU) ? MC : DC;
        end else if (st && op == OP_MTHI) begin
            m_hi = a;
        end else if (st && op == OP_MTLO) begin
            m_lo = a;
        end
    endtask

    task automatic idle(input int n, input logic d, output int nb);
        nb = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, OP_NONE, 32'd0, 32'd0, d);
            nb += int'(obs_busy);
        end
    endtask

    task automatic peek(input string tag, input logic [31:0] hi,
                        input logic [31:0] lo);
        #1;
        chk({tag, "_hi"}, HI, hi);
        chk({tag, "_lo"}, LO, lo);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    int nb, ns;

    initial begin
        reset = 1'b1; start = 1'b0; mdu_op = OP_NONE;
        A = 0; B = 0; d_uses_mdu = 1'b0;
        m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwr = 0; m_rem = 0;
        repeat (2) @(posedge clk);
        step(1'b0, 1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);

        step(1'b0, 1'b1, OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
        idle(MC + 1, 1'b0, nb);
        chk("mult_len", nb, MC);
        peek("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        step(1'b0, 1'b1, OP_MULTU, 32'hFFFF_FFFD, 32'd5, 1'b0);
        idle(MC + 1, 1'b0, nb);
        peek("multu", 32'h0000_0004, 32'hFFFF_FFF1);

        step(1'b0, 1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(DC + 2, 1'b0, nb);
        chk("div_len", nb, DC);
        peek("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        step(1'b0, 1'b1, OP_DIVU, 32'hFFFF_FFFF, 32'd16, 1'b0);
        idle(DC + 1, 1'b0, nb);
        peek("divu", 32'h0000_000F, 32'h0FFF_FFFF);

        step(1'b0, 1'b1, OP_MTHI, 32'h11, 32'd0, 1'b0);
        step(1'b0, 1'b1, OP_MTLO, 32'h22, 32'd0, 1'b0);
        step(1'b0, 1'b1, OP_DIV, 32'd5, 32'd0, 1'b0);
        idle(DC + 2, 1'b0, nb);
        chk("div0_len", nb, DC);
        peek("div0", 32'h11, 32'h22);

        step(1'b0, 1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(DC + 1, 1'b0, nb);
        peek("divovf", 32'h0, 32'h8000_0000);

        step(1'b0, 1'b1, OP_MULT, 32'h0001_0000, 32'h0003_0000, 1'b1);
        step(1'b0, 1'b1, OP_MTHI, 32'hAB, 32'd0, 1'b1);
        ns = int'(obs_stall);
        for (int i = 0; i < MC; i++) begin
            step(1'b0, 1'b0, OP_NONE, 32'd0, 32'd0, 1'b1);
            ns += int'(obs_stall);
        end
        chk("run_stalls", ns, MC);
        step(1'b0, 1'b0, OP_MFHI, 32'd0, 32'd0, 1'b0);
        chk("mfhi_prod", obs_out, 32'h3);

        step(1'b0, 1'b1, OP_MTLO, 32'h1234, 32'd0, 1'b0);
        nb = int'(obs_busy);
        step(1'b0, 1'b1, OP_MULT, 32'd3, 32'd4, 1'b1);
        nb += int'(obs_busy);
        chk("mtlo_nobusy", nb, 0);
        chk("mtlo_val", LO, 32'h1234);
        chk("start_stall", {31'd0, obs_stall}, 32'd1);
        idle(MC + 1, 1'b0, nb);

        step(1'b0, 1'b1, OP_DIV, 32'd100, 32'd7, 1'b0);
        idle(2, 1'b0, nb);
        step(1'b1, 1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        peek("rst", 32'd0, 32'd0);
        idle(DC + 2, 1'b0, nb);
        chk("no_late", nb, 0);
        step(1'b0, 1'b1, OP_MULT, 32'd6, 32'd7, 1'b0);
        idle(MC + 1, 1'b0, nb);
        chk("fresh_len", nb, MC);
        peek("fresh", 32'd0, 32'd42);

        for (int i = 0; i < 600; i++) begin
            logic st;
            st = (m_rem != 0) ? ($urandom_range(0, 7) == 0)
                              : ($urandom_range(0, 2) == 0);
            step($urandom_range(0, 60) == 0, st,
                 4'($urandom_range(0, 8)), rnd_val(), rnd_val(),
                 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
